// File: rtl/adc16dv160_pkg.sv
// Shared definitions for the ADC16DV160 capture path: sequencer state encoding
// and default sizing of the packet counters and acknowledge timeout.
package adc16dv160_pkg;

  localparam int DEFAULT_CNT_W       = 16;
  localparam int DEFAULT_ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } seq_state_e;

endpackage

// File: rtl/adc16dv160_trig_edge.sv
// External trigger register plus rising-edge detector; trig_in is already
// synchronous to aclk, so a single stage is enough to find the edge.
module adc16dv160_trig_edge (
  input  logic aclk,
  input  logic areset,
  input  logic trig_in,
  output logic trig_rise
);

  logic trig_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_in;
    end
  end

  assign trig_rise = trig_in & ~trig_q;

endmodule

// File: rtl/adc16dv160_capture_sequencer.sv
// Acquisition controller: issues start pulses to the packet receiver and uses its
// sr_pc idle flag as acknowledge and completion, with optional trigger and gap.
module adc16dv160_capture_sequencer
  import adc16dv160_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [31:0]      cfg_dsize,
  input  logic [CNT_W-1:0] cfg_npackets,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic             cfg_test,
  input  logic             cfg_ext_trig,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             trig_in,
  input  logic             rx_sr_pc,
  output logic             rx_start,
  output logic [31:0]      rx_dsize,
  output logic             rx_test,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] pkt_count
);

  localparam logic [2:0] S_IDLE      = 3'(ST_IDLE);
  localparam logic [2:0] S_WAIT_TRIG = 3'(ST_WAIT_TRIG);
  localparam logic [2:0] S_ISSUE     = 3'(ST_ISSUE);
  localparam logic [2:0] S_WAIT_ACK  = 3'(ST_WAIT_ACK);
  localparam logic [2:0] S_WAIT_DONE = 3'(ST_WAIT_DONE);
  localparam logic [2:0] S_GAP       = 3'(ST_GAP);

  localparam int               ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] npk_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] pkt_next;
  logic [ACK_W-1:0] ack_cnt;
  logic             ext_q;
  logic             stop_pend;
  logic             trig_rise;
  logic             ack_last;

  logic go_issue;
  logic issue;
  logic finish;
  logic accept;
  logic timeout_set;
  logic stop_set;
  logic pkt_inc;
  logic gap_load;

  adc16dv160_trig_edge u_trig_edge (
    .aclk      (aclk),
    .areset    (areset),
    .trig_in   (trig_in),
    .trig_rise (trig_rise)
  );

  assign pkt_next = pkt_count + CNT_W'(1);
  assign ack_last = (ack_cnt == ACK_LAST);

  // Entering ISSUE while the receiver is already idle fires the start straight
  // away, so start/trigger/gap latencies are one cycle shorter than a visit.
  always_comb begin
    state_d     = state_q;
    go_issue    = 1'b0;
    issue       = 1'b0;
    finish      = 1'b0;
    accept      = 1'b0;
    timeout_set = 1'b0;
    stop_set    = 1'b0;
    pkt_inc     = 1'b0;
    gap_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start && !cmd_stop && (cfg_dsize != 32'd0)) begin
          accept = 1'b1;
          if (cfg_ext_trig) begin
            state_d = S_WAIT_TRIG;
          end else begin
            go_issue = 1'b1;
          end
        end
      end
      S_WAIT_TRIG: begin
        if (cmd_stop) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else if (trig_rise) begin
          go_issue = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cmd_stop) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          go_issue = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        stop_set = cmd_stop;
        if (!rx_sr_pc) begin
          state_d = S_WAIT_DONE;
        end else if (ack_last) begin
          timeout_set = 1'b1;
          finish      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        stop_set = cmd_stop;
        if (rx_sr_pc) begin
          pkt_inc = 1'b1;
          if (((npk_q != '0) && (pkt_next == npk_q)) || stop_pend || cmd_stop) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else if (gap_q != '0) begin
            gap_load = 1'b1;
            state_d  = S_GAP;
          end else if (ext_q) begin
            state_d = S_WAIT_TRIG;
          end else begin
            go_issue = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cmd_stop) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else if (gap_cnt == CNT_W'(1)) begin
          if (ext_q) begin
            state_d = S_WAIT_TRIG;
          end else begin
            go_issue = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_issue) begin
      if (rx_sr_pc) begin
        issue   = 1'b1;
        state_d = S_WAIT_ACK;
      end else begin
        state_d = S_ISSUE;
      end
    end
  end

  // Every output is a register; stop_pend is cleared last so a stop arriving on
  // the completing cycle cannot leak into the next acquisition.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      rx_start    <= 1'b0;
      rx_dsize    <= 32'd0;
      rx_test     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
      npk_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      ext_q       <= 1'b0;
      stop_pend   <= 1'b0;
      ack_cnt     <= '0;
    end else begin
      state_q  <= state_d;
      rx_start <= issue;
      done     <= finish;
      busy     <= (state_d != S_IDLE);

      if (accept) begin
        rx_dsize    <= cfg_dsize;
        rx_test     <= cfg_test;
        npk_q       <= cfg_npackets;
        gap_q       <= cfg_gap;
        ext_q       <= cfg_ext_trig;
        pkt_count   <= '0;
        timeout_err <= 1'b0;
        stop_pend   <= 1'b0;
      end

      if (timeout_set) begin
        timeout_err <= 1'b1;
      end
      if (stop_set) begin
        stop_pend <= 1'b1;
      end
      if (finish) begin
        stop_pend <= 1'b0;
      end
      if (pkt_inc) begin
        pkt_count <= pkt_next;
      end

      if (gap_load) begin
        gap_cnt <= gap_q;
      end else if (state_q == S_GAP) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end

      if (issue) begin
        ack_cnt <= '0;
      end else if (state_q == S_WAIT_ACK) begin
        ack_cnt <= ack_cnt + ACK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc16dv160_capture_sequencer.sv
// Directed bench for the capture sequencer with a small receiver model that
// answers rx_start by dropping sr_pc for a fixed packet length.
module tb_adc16dv160_capture_sequencer;

  localparam int ACK_TO = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] cfg_dsize = 32'd0;
  logic [15:0] cfg_npackets = 16'd0;
  logic [15:0] cfg_gap = 16'd0;
  logic        cfg_test = 1'b0;
  logic        cfg_ext_trig = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        trig_in = 1'b0;
  logic        rx_sr_pc = 1'b0;
  logic        rx_start;
  logic [31:0] rx_dsize;
  logic        rx_test;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int rx_len = 8;
  int rx_busy_cnt = 0;
  int rx_init_cnt = 0;
  bit rx_ignore = 1'b0;

  adc16dv160_capture_sequencer #(.CNT_W(16), .ACK_TIMEOUT(ACK_TO)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_dsize    (cfg_dsize),
    .cfg_npackets (cfg_npackets),
    .cfg_gap      (cfg_gap),
    .cfg_test     (cfg_test),
    .cfg_ext_trig (cfg_ext_trig),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .trig_in      (trig_in),
    .rx_sr_pc     (rx_sr_pc),
    .rx_start     (rx_start),
    .rx_dsize     (rx_dsize),
    .rx_test      (rx_test),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .pkt_count    (pkt_count)
  );

  always #5 aclk = ~aclk;

  // Receiver: INIT after reset, then idle until a start drops sr_pc for rx_len cycles.
  always @(posedge aclk) begin
    if (areset) begin
      rx_sr_pc    <= 1'b0;
      rx_init_cnt <= 5;
      rx_busy_cnt <= 0;
    end else if (rx_init_cnt != 0) begin
      rx_init_cnt <= rx_init_cnt - 1;
      if (rx_init_cnt == 1) rx_sr_pc <= 1'b1;
    end else if (rx_start && rx_sr_pc && !rx_ignore) begin
      rx_sr_pc    <= 1'b0;
      rx_busy_cnt <= rx_len;
    end else if (!rx_sr_pc) begin
      if (rx_busy_cnt <= 1) rx_sr_pc <= 1'b1;
      else rx_busy_cnt <= rx_busy_cnt - 1;
    end
  end

  always @(posedge aclk) begin
    if (rx_start) start_cnt <= start_cnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  function automatic logic sig_now(input int sel);
    case (sel)
      0:       return rx_start;
      1:       return done;
      2:       return rx_sr_pc;
      default: return timeout_err;
    endcase
  endfunction

  // Ticks until the selected signal is high; n is the cycles waited or -1 on expiry.
  task automatic wait_sig(input int sel, input int budget, output int n);
    n = 0;
    while (!sig_now(sel) && n < budget) begin
      tick();
      n++;
    end
    if (!sig_now(sel)) n = -1;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rx_start !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got start=%b done=%b to=%b expected 0", rx_start, done, timeout_err); end
    checks++; if (pkt_count !== 16'd0 || rx_dsize !== 32'd0 || rx_test !== 1'b0) begin errors++; $display("[TB] FAIL reset_values: got cnt=%0d dsize=%0d test=%b expected 0", pkt_count, rx_dsize, rx_test); end
    areset = 1'b0;
  endtask

  task automatic test_single();
    int n;
    int s0;
    wait_sig(2, 20, n);
    checks++; if (n < 0) begin errors++; $display("[TB] FAIL rx_init: got timeout expected idle receiver"); end
    cfg_dsize = 32'd256; cfg_npackets = 16'd1; cfg_gap = 16'd0; cfg_ext_trig = 1'b0; cfg_test = 1'b1;
    s0 = start_cnt;
    pulse_start();
    checks++; if (rx_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start_latency: got %b expected 1", rx_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    checks++; if (rx_dsize !== 32'd256 || rx_test !== 1'b1) begin errors++; $display("[TB] FAIL single_cfg: got dsize=%0d test=%b expected 256 1", rx_dsize, rx_test); end
    tick();
    checks++; if (rx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_width: got %b expected 0", rx_start); end
    wait_sig(2, 50, n);
    checks++; if (n < 0 || done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_early: got n=%0d done=%b expected done 0", n, done); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done: got done=%b busy=%b expected 1 0", done, busy); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", pkt_count); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_width: got %b expected 0", done); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("[TB] FAIL single_num_starts: got %0d expected 1", start_cnt - s0); end
  endtask

  task automatic test_burst();
    int n;
    int s0;
    cfg_npackets = 16'd4; cfg_gap = 16'd10; cfg_test = 1'b0;
    s0 = start_cnt;
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      tick();
      wait_sig(2, 50, n);
      if (k < 4) begin
        wait_sig(0, 50, n);
        checks++; if (n !== 11) begin errors++; $display("[TB] FAIL burst_spacing: got %0d expected 11", n); end
        checks++; if (pkt_count !== 16'(k)) begin errors++; $display("[TB] FAIL burst_count: got %0d expected %0d", pkt_count, k); end
      end else begin
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || pkt_count !== 16'd4) begin errors++; $display("[TB] FAIL burst_end: got done=%b busy=%b cnt=%0d expected 1 0 4", done, busy, pkt_count); end
      end
    end
    checks++; if (start_cnt - s0 !== 4) begin errors++; $display("[TB] FAIL burst_num_starts: got %0d expected 4", start_cnt - s0); end
  endtask

  task automatic test_ext_trig();
    int n;
    int s0;
    cfg_npackets = 16'd2; cfg_gap = 16'd0; cfg_ext_trig = 1'b1;
    s0 = start_cnt;
    pulse_start();
    repeat (3) tick();
    checks++; if (busy !== 1'b1 || rx_start !== 1'b0) begin errors++; $display("[TB] FAIL trig_wait: got busy=%b start=%b expected 1 0", busy, rx_start); end
    trig_in = 1'b1;
    tick();
    checks++; if (rx_start !== 1'b1) begin errors++; $display("[TB] FAIL trig_latency: got %b expected 1", rx_start); end
    tick();
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    wait_sig(2, 50, n);
    tick();
    repeat (5) tick();
    checks++; if (start_cnt - s0 !== 1 || pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL trig_ignored_edge: got starts=%0d cnt=%0d expected 1 1", start_cnt - s0, pkt_count); end
    trig_in = 1'b1;
    tick();
    checks++; if (rx_start !== 1'b1) begin errors++; $display("[TB] FAIL trig_second: got %b expected 1", rx_start); end
    trig_in = 1'b0;
    tick();
    wait_sig(2, 50, n);
    tick();
    checks++; if (done !== 1'b1 || pkt_count !== 16'd2 || start_cnt - s0 !== 2) begin errors++; $display("[TB] FAIL trig_end: got done=%b cnt=%0d starts=%0d expected 1 2 2", done, pkt_count, start_cnt - s0); end
    cfg_ext_trig = 1'b0;
  endtask

  task automatic test_continuous_stop();
    int n;
    int s0;
    cfg_npackets = 16'd0; cfg_gap = 16'd2;
    s0 = start_cnt;
    pulse_start();
    tick();
    wait_sig(2, 50, n);
    wait_sig(0, 50, n);
    checks++; if (n !== 3 || pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL cont_second: got n=%0d cnt=%0d expected 3 1", n, pkt_count); end
    tick();
    tick();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL cont_stop_pending: got busy=%b expected 1", busy); end
    wait_sig(2, 50, n);
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || pkt_count !== 16'd2) begin errors++; $display("[TB] FAIL cont_stop_done: got done=%b busy=%b cnt=%0d expected 1 0 2", done, busy, pkt_count); end
    repeat (20) tick();
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("[TB] FAIL cont_no_restart: got %0d expected 2", start_cnt - s0); end
  endtask

  task automatic test_timeout();
    int n;
    cfg_npackets = 16'd1; cfg_gap = 16'd0;
    rx_ignore = 1'b1;
    pulse_start();
    wait_sig(3, 50, n);
    checks++; if (n !== ACK_TO) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", n, ACK_TO); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_done: got done=%b busy=%b expected 1 0", done, busy); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err); end
    rx_ignore = 1'b0;
    pulse_start();
    checks++; if (timeout_err !== 1'b0 || rx_start !== 1'b1) begin errors++; $display("[TB] FAIL timeout_clear: got to=%b start=%b expected 0 1", timeout_err, rx_start); end
    tick();
    wait_sig(2, 50, n);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_recover: got done=%b expected 1", done); end
  endtask

  task automatic test_edge_cases();
    int n;
    int s0;
    cfg_dsize = 32'd0; cfg_npackets = 16'd1; cfg_gap = 16'd0;
    s0 = start_cnt;
    pulse_start();
    tick();
    checks++; if (busy !== 1'b0 || start_cnt !== s0) begin errors++; $display("[TB] FAIL dsize_zero: got busy=%b starts=%0d expected 0 %0d", busy, start_cnt, s0); end
    cfg_dsize = 32'd256;
    cmd_stop = 1'b1;
    pulse_start();
    cmd_stop = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || start_cnt !== s0) begin errors++; $display("[TB] FAIL start_stop: got busy=%b starts=%0d expected 0 %0d", busy, start_cnt, s0); end
    cfg_dsize = 32'd100; cfg_test = 1'b0;
    pulse_start();
    cfg_dsize = 32'd999; cfg_test = 1'b1;
    repeat (3) tick();
    checks++; if (rx_dsize !== 32'd100 || rx_test !== 1'b0) begin errors++; $display("[TB] FAIL cfg_stable: got dsize=%0d test=%b expected 100 0", rx_dsize, rx_test); end
    wait_sig(2, 50, n);
    tick();
    cfg_dsize = 32'd64; cfg_test = 1'b0; cfg_npackets = 16'd3;
    pulse_start();
    tick();
    wait_sig(2, 50, n);
    tick();
    checks++; if (rx_start !== 1'b1 || pkt_count !== 16'd1) begin errors++; $display("[TB] FAIL reset_mid_pre: got start=%b cnt=%0d expected 1 1", rx_start, pkt_count); end
    repeat (3) tick();
    areset = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || pkt_count !== 16'd0 || rx_dsize !== 32'd0) begin errors++; $display("[TB] FAIL reset_mid: got busy=%b cnt=%0d dsize=%0d expected 0 0 0", busy, pkt_count, rx_dsize); end
    areset = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    $display("[TB] start");
    tick();
    test_reset();
    test_single();
    test_burst();
    test_ext_trig();
    test_continuous_stop();
    test_timeout();
    test_edge_cases();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
